// File: rtl/vtw_vector_sequencer.sv
// Vector sequencer: fetches vector records, expands repeats and paces tester cycles.
// Optional build macro VTW_SEQ_CYCLE_LIMIT_EN adds a cycle_limit input and a limit_hit flag.
module vtw_vector_sequencer #(
    parameter int INT_W = 32,
    parameter int RPT_W = 16,
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [PER_W-1:0] period,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [RPT_W-1:0] vec_repeat,
    input  logic             vec_last,
    output logic             tester_sync,
    output logic [INT_W-1:0] cur_vector_number,
    output logic [INT_W-1:0] cur_cycle_number,
    output logic             busy,
    output logic             done,
`ifdef VTW_SEQ_CYCLE_LIMIT_EN
    input  logic [INT_W-1:0] cycle_limit,
    output logic             limit_hit,
`endif
    output logic             underrun
);

    typedef enum logic [1:0] {IDLE, FETCH, RUN, DONE} state_t;

    localparam logic [INT_W-1:0] ONE_I = 1;
    localparam logic [PER_W-1:0] ONE_P = 1;
    localparam logic [RPT_W-1:0] ONE_R = 1;

    state_t           state_reg, state_next;
    logic [PER_W-1:0] per_lat_reg, per_lat_next;
    logic [PER_W-1:0] per_cnt_reg, per_cnt_next;
    logic [RPT_W-1:0] rpt_left_reg, rpt_left_next;
    logic             last_flag_reg, last_flag_next;
    logic             first_reg, first_next;
    logic             sync_reg, sync_next;
    logic [INT_W-1:0] vec_num_reg, vec_num_next;
    logic [INT_W-1:0] cyc_num_reg, cyc_num_next;
    logic             underrun_reg, underrun_next;
    logic             at_boundary;
    logic             would_hit;
    logic             accept;

`ifdef VTW_SEQ_CYCLE_LIMIT_EN
    logic [INT_W-1:0] limit_reg, limit_next;
    logic             limit_hit_reg, limit_hit_next;

    // The first accept always lands on cycle 0, so only later ticks can reach the limit.
    assign would_hit = (limit_reg != '0) && !first_reg && ((cyc_num_reg + ONE_I) == limit_reg);
    assign limit_hit = limit_hit_reg;
`else
    assign would_hit = 1'b0;
`endif

    assign at_boundary = (state_reg == RUN) && (per_cnt_reg == '0) && (rpt_left_reg == '0);
    // A limit-terminated boundary must not consume a record it will never play.
    assign vec_ready   = !stop && ((state_reg == FETCH) ||
                                   (at_boundary && !last_flag_reg && !would_hit));
    assign accept      = vec_valid && vec_ready;

    always_comb begin
        state_next     = state_reg;
        per_lat_next   = per_lat_reg;
        per_cnt_next   = per_cnt_reg;
        rpt_left_next  = rpt_left_reg;
        last_flag_next = last_flag_reg;
        first_next     = first_reg;
        sync_next      = sync_reg;
        vec_num_next   = vec_num_reg;
        cyc_num_next   = cyc_num_reg;
        underrun_next  = underrun_reg;
`ifdef VTW_SEQ_CYCLE_LIMIT_EN
        limit_next     = limit_reg;
        limit_hit_next = limit_hit_reg;
`endif
        if (stop && (state_reg != IDLE)) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_next    = FETCH;
                        per_lat_next  = (period == '0) ? ONE_P : period;
                        first_next    = 1'b1;
                        underrun_next = 1'b0;
`ifdef VTW_SEQ_CYCLE_LIMIT_EN
                        limit_next     = cycle_limit;
                        limit_hit_next = 1'b0;
`endif
                    end
                end
                FETCH, RUN: begin
                    if (accept) begin
                        state_next     = RUN;
                        sync_next      = !sync_reg;
                        vec_num_next   = first_reg ? '0 : vec_num_reg + ONE_I;
                        cyc_num_next   = first_reg ? '0 : cyc_num_reg + ONE_I;
                        first_next     = 1'b0;
                        rpt_left_next  = vec_repeat;
                        last_flag_next = vec_last;
                        per_cnt_next   = per_lat_reg - ONE_P;
                    end else if (state_reg == RUN) begin
                        if (per_cnt_reg != '0) begin
                            per_cnt_next = per_cnt_reg - ONE_P;
                        end else if (would_hit && !(rpt_left_reg == '0 && last_flag_reg)) begin
                            state_next = DONE;
`ifdef VTW_SEQ_CYCLE_LIMIT_EN
                            limit_hit_next = 1'b1;
`endif
                        end else if (rpt_left_reg != '0) begin
                            sync_next     = !sync_reg;
                            cyc_num_next  = cyc_num_reg + ONE_I;
                            rpt_left_next = rpt_left_reg - ONE_R;
                            per_cnt_next  = per_lat_reg - ONE_P;
                        end else if (last_flag_reg) begin
                            state_next = DONE;
                        end else begin
                            underrun_next = 1'b1;
                        end
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            per_lat_reg   <= '0;
            per_cnt_reg   <= '0;
            rpt_left_reg  <= '0;
            last_flag_reg <= 1'b0;
            first_reg     <= 1'b1;
            sync_reg      <= 1'b0;
            vec_num_reg   <= '0;
            cyc_num_reg   <= '0;
            underrun_reg  <= 1'b0;
`ifdef VTW_SEQ_CYCLE_LIMIT_EN
            limit_reg     <= '0;
            limit_hit_reg <= 1'b0;
`endif
        end else begin
            state_reg     <= state_next;
            per_lat_reg   <= per_lat_next;
            per_cnt_reg   <= per_cnt_next;
            rpt_left_reg  <= rpt_left_next;
            last_flag_reg <= last_flag_next;
            first_reg     <= first_next;
            sync_reg      <= sync_next;
            vec_num_reg   <= vec_num_next;
            cyc_num_reg   <= cyc_num_next;
            underrun_reg  <= underrun_next;
`ifdef VTW_SEQ_CYCLE_LIMIT_EN
            limit_reg     <= limit_next;
            limit_hit_reg <= limit_hit_next;
`endif
        end
    end

    assign tester_sync       = sync_reg;
    assign cur_vector_number = vec_num_reg;
    assign cur_cycle_number  = cyc_num_reg;
    assign busy              = (state_reg == FETCH) || (state_reg == RUN);
    assign done              = (state_reg == DONE);
    assign underrun          = underrun_reg;

endmodule
